uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance among NUM_REQ byte requesters.
- Round-robin arbitration, with optional packet lock: a requester keeps the grant until it flags the last byte, or until PKT_MAX bytes have been sent.
- Sequences the uart_tx start/done handshake and sits directly in front of the uart_tx instance in the serial output path.

Parameters:
- NUM_REQ, 4: number of requesters; ≥2.
- DATA_WIDTH, 8: byte width; must match uart_tx DATA_WIDTH.
- PKT_MAX, 16: maximum bytes per locked grant before forced release; ≥1.

Ports:
- in_clk  input  1  system clock.
- in_rst_n  input  1  synchronous reset, active-low.
- in_en  input  1  clock enable; when low, all state and outputs hold.
- in_req_valid  input  NUM_REQ  per-requester byte valid; must stay high until accepted.
- in_req_last  input  NUM_REQ  per-requester last-byte-of-packet flag, qualified by valid.
- in_req_data  input  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_req_ready_reg  output  NUM_REQ  one-hot accept; transfer occurs when valid[i] and ready[i] are high in the same cycle.
- out_tx_start_reg  output  1  drives uart_tx in_start.
- out_tx_data_reg  output  DATA_WIDTH  drives uart_tx in_data.
- in_tx_done  input  1  from uart_tx out_done_reg: 1 = idle, 0 = transmitting.
- out_grant_id_reg  output  clog2(NUM_REQ)  index of the current or last granted requester.
- out_busy_reg  output  1  high in any state other than IDLE.

Behaviour:
- Reset (in_rst_n=0 at posedge) has priority over in_en and takes effect mid-operation:
  - state=IDLE, rr_ptr=0, lock=0, pkt_cnt=0.
  - All outputs are 0, including ready, start, data, grant_id and busy.
  - An in-flight byte may be cut off; the system resets uart_tx together with this block.
- States are IDLE, GRANT, START and WAIT. All transitions below apply only on cycles where in_en=1.
- IDLE:
  - If any valid is high, select the first requester with valid=1 scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - On selection: grant_id <= sel, ready[sel] <= 1, go to GRANT.
  - If no valid is high, remain in IDLE.
- GRANT:
  - If valid[grant_id]=1 (ready[grant_id] is already 1):
    - Capture the data into out_tx_data_reg and the last flag into an internal register.
    - Clear ready, set out_tx_start_reg <= 1, pkt_cnt <= pkt_cnt+1, go to START.
    - Exactly one ready pulse occurs per transferred byte.
  - If valid[grant_id]=0, which is only possible while locked mid-packet:
    - Hold ready high and wait.
    - Other requesters are not served.
- START:
  - Hold start=1 until in_tx_done=0 is sampled, then start <= 0 and go to WAIT.
  - No timeout. Start is never dropped before done falls, so uart_tx cannot miss it even if its own in_en is gated.
- WAIT: on in_tx_done=1, decide as follows.
  - Continue packet, when last=0 and pkt_cnt<PKT_MAX: lock <= 1, ready[grant_id] <= 1, go to GRANT.
  - Release, otherwise (last=1 or pkt_cnt==PKT_MAX): lock <= 0, pkt_cnt <= 0, rr_ptr <= (grant_id+1) mod NUM_REQ, go to IDLE.
  - A requester that wants no locking sets last=1 on every byte.
- Forced release at PKT_MAX: the requester must re-arbitrate, and its next byte starts a new packet from the bus's point of view.
- Requests that appear while the block is busy wait; they do not preempt the current grant.
- Simultaneous valids in IDLE are resolved by rr_ptr order. A starvation bound applies: every valid requester is served within NUM_REQ-1 grants.
- Minimum latency from valid in IDLE to start=1 is 2 cycles (IDLE→GRANT, GRANT→START).
- out_tx_data_reg holds its value from capture until the next capture.
- uart_tx sees a stable in_data whenever start=1.
- pkt_cnt is clog2(PKT_MAX+1) bits wide and never wraps.
- An unreachable state encoding recovers to IDLE with reset values.

Decomposition:
- Shared package (uart_pkg):
  - Controller state encoding localparams for IDLE/GRANT/START/WAIT.
  - Common DATA_WIDTH default.
- One natural sub-module: rr_pick.
  - Combinational: rotated priority search over NUM_REQ.
  - Inputs are valid and rr_ptr; outputs are sel index and any_valid.
  - Reusable by later arbiters.

Test Plan:
- Single byte: req1 valid, data=0x5A, last=1, with done modelled by a uart_tx stub.
  - ready[1] pulses once.
  - start rises 2 cycles after valid and holds until done=0.
  - data=0x5A throughout.
  - Afterwards rr_ptr=2 and busy=0.
- Contention: req0, req2 and req3 valid simultaneously with last=1, rr_ptr=0.
  - Grant order is 0, 2, 3, then back to idle.
  - A new req0 asserted during req3's byte is served after req3.
- Packet lock: req2 sends 3 bytes 0x01, 0x02, 0x03 (last on the third) while req0 is valid throughout.
  - All three req2 bytes are sent before req0.
  - A 5-cycle valid gap mid-packet keeps ready[2] high and does not grant req0.
- PKT_MAX=4: req1 streams 6 bytes with last=0 while req3 is valid.
  - Order is 4×req1, then req3, then the remaining 2×req1.
- Handshake robustness: stub delays done=0 by 10 cycles after start.
  - start stays 1 for all 10 cycles and drops the cycle after done=0 is sampled.
  - Holding in_en=0 for 3 cycles freezes all outputs.
- Reset mid-WAIT: drive in_rst_n=0 for one cycle.
  - Next cycle: ready=0, start=0, busy=0, grant_id=0, data=0.
  - The following arbitration starts from rr_ptr=0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared arbiter state encoding and UART data-width default
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_GRANT = 2'd1;
  localparam logic [1:0] C_ST_START = 2'd2;
  localparam logic [1:0] C_ST_WAIT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = C_ST_IDLE,
    ST_GRANT = C_ST_GRANT,
    ST_START = C_ST_START,
    ST_WAIT  = C_ST_WAIT
  } arb_state_e;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter_if : requester byte bus plus uart_tx start/done handshake
// Rev 1.0
// ============================================================================
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [NUM_REQ-1:0]            in_req_valid;
  logic [NUM_REQ-1:0]            in_req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_data;
  logic [NUM_REQ-1:0]            out_req_ready_reg;
  logic                          out_tx_start_reg;
  logic [DATA_WIDTH-1:0]         out_tx_data_reg;
  logic                          in_tx_done;

  modport master (
    output in_req_valid, in_req_last, in_req_data, in_tx_done,
    input  out_req_ready_reg, out_tx_start_reg, out_tx_data_reg
  );

  modport slave (
    input  in_req_valid, in_req_last, in_req_data, in_tx_done,
    output out_req_ready_reg, out_tx_start_reg, out_tx_data_reg
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational rotated-priority search starting at i_rr_ptr
// Rev 1.0
// ============================================================================
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = idx_width(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] i_valid,
  input  wire logic [PTR_W-1:0]   i_rr_ptr,
  output logic      [PTR_W-1:0]   o_sel,
  output logic                    o_any_valid
);

  int w_idx;

  // Scan from farthest to nearest so the entry closest to the pointer wins.
  always_comb begin
    o_sel       = '0;
    o_any_valid = |i_valid;
    w_idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(i_rr_ptr) + k) % NUM_REQ;
      if (i_valid[PTR_W'(w_idx)]) begin
        o_sel = PTR_W'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : round-robin, packet-locking share of one uart_tx
// Rev 1.0
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PKT_MAX    = 16,
  localparam int C_GRANT_W = idx_width(NUM_REQ),
  localparam int C_CNT_W   = $clog2(PKT_MAX + 1)
) (
  input  wire logic             in_clk,
  input  wire logic             in_rst_n,
  input  wire logic             in_en,
  uart_tx_arbiter_if.slave      bus,
  output logic [C_GRANT_W-1:0]  out_grant_id_reg,
  output logic                  out_busy_reg
);

  localparam logic [NUM_REQ-1:0] C_ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_e             r_state, w_state_nxt;
  logic [C_GRANT_W-1:0]   r_rr_ptr, w_rr_ptr_nxt, w_sel, w_grant_nxt;
  logic                   r_lock, w_lock_nxt;
  logic                   r_last, w_last_nxt;
  logic [C_CNT_W-1:0]     r_pkt_cnt, w_pkt_cnt_nxt;
  logic [NUM_REQ-1:0]     w_ready_nxt;
  logic                   w_start_nxt, w_busy_nxt, w_any_valid;
  logic [DATA_WIDTH-1:0]  w_data_nxt;
  logic [DATA_WIDTH-1:0]  w_req_data [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_data[gi] = bus.in_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (C_GRANT_W)
  ) u_rr_pick (
    .i_valid     (bus.in_req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_sel       (w_sel),
    .o_any_valid (w_any_valid)
  );

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_state               <= ST_IDLE;
      r_rr_ptr              <= '0;
      r_lock                <= 1'b0;
      r_last                <= 1'b0;
      r_pkt_cnt             <= '0;
      bus.out_req_ready_reg <= '0;
      bus.out_tx_start_reg  <= 1'b0;
      bus.out_tx_data_reg   <= '0;
      out_grant_id_reg      <= '0;
      out_busy_reg          <= 1'b0;
    end else if (in_en) begin
      r_state               <= w_state_nxt;
      r_rr_ptr              <= w_rr_ptr_nxt;
      r_lock                <= w_lock_nxt;
      r_last                <= w_last_nxt;
      r_pkt_cnt             <= w_pkt_cnt_nxt;
      bus.out_req_ready_reg <= w_ready_nxt;
      bus.out_tx_start_reg  <= w_start_nxt;
      bus.out_tx_data_reg   <= w_data_nxt;
      out_grant_id_reg      <= w_grant_nxt;
      out_busy_reg          <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_lock_nxt    = r_lock;
    w_last_nxt    = r_last;
    w_pkt_cnt_nxt = r_pkt_cnt;
    w_ready_nxt   = bus.out_req_ready_reg;
    w_start_nxt   = bus.out_tx_start_reg;
    w_data_nxt    = bus.out_tx_data_reg;
    w_grant_nxt   = out_grant_id_reg;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_grant_nxt = w_sel;
          w_ready_nxt = C_ONE_HOT0 << w_sel;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // While locked with valid low, ready stays up and nobody else is served.
        if (bus.in_req_valid[out_grant_id_reg]) begin
          w_data_nxt    = w_req_data[out_grant_id_reg];
          w_last_nxt    = bus.in_req_last[out_grant_id_reg];
          w_ready_nxt   = '0;
          w_start_nxt   = 1'b1;
          w_pkt_cnt_nxt = r_pkt_cnt + 1'b1;
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        if (!bus.in_tx_done) begin
          w_start_nxt = 1'b0;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.in_tx_done) begin
          if (!r_last && (r_pkt_cnt < C_CNT_W'(PKT_MAX))) begin
            w_lock_nxt  = 1'b1;
            w_ready_nxt = C_ONE_HOT0 << out_grant_id_reg;
            w_state_nxt = ST_GRANT;
          end else begin
            w_lock_nxt    = 1'b0;
            w_pkt_cnt_nxt = '0;
            w_rr_ptr_nxt  = (out_grant_id_reg == C_GRANT_W'(NUM_REQ - 1)) ?
                            '0 : out_grant_id_reg + 1'b1;
            w_state_nxt   = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_rr_ptr_nxt  = '0;
        w_lock_nxt    = 1'b0;
        w_last_nxt    = 1'b0;
        w_pkt_cnt_nxt = '0;
        w_ready_nxt   = '0;
        w_start_nxt   = 1'b0;
        w_data_nxt    = '0;
        w_grant_nxt   = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : directed self-checking bench with a uart_tx done stub
// Rev 1.0
// ============================================================================
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int PKT_MAX = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b1;
  logic [1:0] grant_id;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .PKT_MAX    (PKT_MAX)
  ) dut (
    .in_clk           (clk),
    .in_rst_n         (rst_n),
    .in_en            (en),
    .bus              (bus),
    .out_grant_id_reg (grant_id),
    .out_busy_reg     (busy)
  );

  // Requester byte queues: {last, data}; gap[i] forces valid low.
  logic [8:0] q [NUM_REQ][$];
  bit         gap [NUM_REQ];
  int         log_id [$];
  logic [7:0] log_data [$];

  always @(negedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (q[i].size() > 0 && !gap[i]) begin
        bus.in_req_valid[i]          = 1'b1;
        bus.in_req_last[i]           = q[i][0][8];
        bus.in_req_data[i*DW +: DW]  = q[i][0][7:0];
      end else begin
        bus.in_req_valid[i]          = 1'b0;
        bus.in_req_last[i]           = 1'b0;
        bus.in_req_data[i*DW +: DW]  = '0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.in_req_valid[i] === 1'b1 && bus.out_req_ready_reg[i] === 1'b1) begin
          log_id.push_back(i);
          log_data.push_back(bus.in_req_data[i*DW +: DW]);
          void'(q[i].pop_front());
        end
      end
    end
  end

  // uart_tx stub: done falls stub_dly cycles after start is seen, low for stub_len.
  int stub_dly = 0;
  int stub_len = 4;
  int stub_cnt = 0;
  bit stub_busy = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.in_tx_done <= 1'b1;
      stub_busy      <= 1'b0;
      stub_cnt       <= 0;
    end else if (en) begin
      if (stub_busy) begin
        if (stub_cnt >= stub_len - 1) begin
          bus.in_tx_done <= 1'b1;
          stub_busy      <= 1'b0;
          stub_cnt       <= 0;
        end else begin
          stub_cnt <= stub_cnt + 1;
        end
      end else if (bus.out_tx_start_reg) begin
        if (stub_cnt >= stub_dly) begin
          bus.in_tx_done <= 1'b0;
          stub_busy      <= 1'b1;
          stub_cnt       <= 0;
        end else begin
          stub_cnt <= stub_cnt + 1;
        end
      end
    end
  end

  function automatic bit queues_empty();
    for (int i = 0; i < NUM_REQ; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (!busy && queues_empty()) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.out_req_ready_reg !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", bus.out_req_ready_reg); end
    checks++; if (bus.out_tx_start_reg !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", bus.out_tx_start_reg); end
    checks++; if (bus.out_tx_data_reg !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.out_tx_data_reg); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int         exp_id [$];
    logic [7:0] exp_d [$];
    bit         found, ok;
    exp_id = '{0, 2, 3, 0};
    exp_d  = '{8'hA0, 8'hA2, 8'hA3, 8'hB0};
    log_id.delete(); log_data.delete();
    q[0].push_back({1'b1, 8'hA0});
    q[2].push_back({1'b1, 8'hA2});
    q[3].push_back({1'b1, 8'hA3});
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy && grant_id == 2'd3) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL contention_grant3 got grant %0d want 3", grant_id); end
    q[0].push_back({1'b1, 8'hB0});
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL contention_timeout got busy %b want idle", busy); end
    checks++; if (log_id.size() != 4) begin errors++; $display("FAIL contention_count got %0d want 4", log_id.size()); end
    for (int i = 0; i < 4 && i < log_id.size(); i++) begin
      checks++;
      if (log_id[i] != exp_id[i] || log_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL contention_order[%0d] got id %0d data %h want id %0d data %h", i, log_id[i], log_data[i], exp_id[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_single_byte();
    bit ok;
    int bad_data;
    int hold;
    log_id.delete(); log_data.delete();
    q[1].push_back({1'b1, 8'h5A});
    @(negedge clk);
    checks++; if (bus.out_req_ready_reg !== 4'b0010 || bus.out_tx_start_reg !== 1'b0) begin errors++; $display("FAIL single_grant got ready %b start %b want 0010 0", bus.out_req_ready_reg, bus.out_tx_start_reg); end
    @(negedge clk);
    checks++; if (bus.out_tx_start_reg !== 1'b1 || bus.out_req_ready_reg !== 4'b0000) begin errors++; $display("FAIL single_start got start %b ready %b want 1 0000", bus.out_tx_start_reg, bus.out_req_ready_reg); end
    bad_data = 0;
    hold = 0;
    while (bus.out_tx_start_reg === 1'b1 && hold < 50) begin
      if (bus.out_tx_data_reg !== 8'h5A) bad_data++;
      hold++;
      @(negedge clk);
    end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL single_data got %0d bad cycles data %h want 5a", bad_data, bus.out_tx_data_reg); end
    checks++; if (bus.in_tx_done !== 1'b0) begin errors++; $display("FAIL single_start_drop got done %b want 0 when start falls", bus.in_tx_done); end
    wait_idle(100, ok);
    checks++; if (!ok || busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy %b want 0", busy); end
    checks++; if (log_id.size() != 1 || log_id[0] != 1 || log_data[0] !== 8'h5A) begin errors++; $display("FAIL single_pulses got %0d transfers want 1 from req1", log_id.size()); end
    // rr_ptr should now be 2: req2 beats req0.
    log_id.delete(); log_data.delete();
    q[0].push_back({1'b1, 8'hC0});
    q[2].push_back({1'b1, 8'hC2});
    wait_idle(200, ok);
    checks++; if (!ok || log_id.size() != 2 || log_id[0] != 2 || log_id[1] != 0) begin errors++; $display("FAIL single_rrptr got first id %0d count %0d want 2 then 0", (log_id.size() > 0) ? log_id[0] : -1, log_id.size()); end
  endtask

  task automatic test_packet_lock();
    int         exp_id [$];
    logic [7:0] exp_d [$];
    bit         found, ok;
    exp_id = '{2, 2, 2, 0};
    exp_d  = '{8'h01, 8'h02, 8'h03, 8'hD0};
    log_id.delete(); log_data.delete();
    q[2].push_back({1'b0, 8'h01});
    q[2].push_back({1'b0, 8'h02});
    q[2].push_back({1'b1, 8'h03});
    q[0].push_back({1'b1, 8'hD0});
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (log_id.size() >= 1) begin found = 1'b1; break; end
    end
    gap[2] = 1'b1;
    checks++; if (!found) begin errors++; $display("FAIL lock_first got %0d transfers want 1", log_id.size()); end
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.out_req_ready_reg[2] === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL lock_regrant got ready %b want 0100", bus.out_req_ready_reg); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_req_ready_reg !== 4'b0100 || grant_id !== 2'd2 || log_id.size() != 1) begin
        errors++;
        $display("FAIL lock_gap[%0d] got ready %b grant %0d transfers %0d want 0100 2 1", c, bus.out_req_ready_reg, grant_id, log_id.size());
      end
    end
    gap[2] = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok || log_id.size() != 4) begin errors++; $display("FAIL lock_count got %0d want 4", log_id.size()); end
    for (int i = 0; i < 4 && i < log_id.size(); i++) begin
      checks++;
      if (log_id[i] != exp_id[i] || log_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL lock_order[%0d] got id %0d data %h want id %0d data %h", i, log_id[i], log_data[i], exp_id[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_pkt_max();
    int         exp_id [$];
    logic [7:0] exp_d [$];
    bit         ok;
    exp_id = '{1, 1, 1, 1, 3, 1, 1};
    exp_d  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h33, 8'h14, 8'h15};
    log_id.delete(); log_data.delete();
    for (int k = 0; k < 6; k++) q[1].push_back({(k == 5), 8'(8'h10 + k)});
    q[3].push_back({1'b1, 8'h33});
    wait_idle(600, ok);
    checks++; if (!ok || log_id.size() != 7) begin errors++; $display("FAIL pktmax_count got %0d want 7", log_id.size()); end
    for (int i = 0; i < 7 && i < log_id.size(); i++) begin
      checks++;
      if (log_id[i] != exp_id[i] || log_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL pktmax_order[%0d] got id %0d data %h want id %0d data %h", i, log_id[i], log_data[i], exp_id[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_handshake();
    bit ok, found;
    int hold, bad;
    stub_dly = 10;
    log_id.delete(); log_data.delete();
    q[2].push_back({1'b1, 8'hC3});
    @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_req_ready_reg !== 4'b0100 || bus.out_tx_start_reg !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd2) begin
        errors++;
        $display("FAIL freeze[%0d] got ready %b start %b busy %b grant %0d want 0100 0 1 2", c, bus.out_req_ready_reg, bus.out_tx_start_reg, busy, grant_id);
      end
    end
    en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_tx_start_reg === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL hs_start got %b want 1", bus.out_tx_start_reg); end
    hold = 0;
    bad  = 0;
    while (bus.in_tx_done === 1'b1 && hold < 40) begin
      if (bus.out_tx_start_reg !== 1'b1) bad++;
      hold++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hs_hold got %0d cycles with start low want 0", bad); end
    checks++; if (hold < 10) begin errors++; $display("FAIL hs_len got %0d cycles want at least 10", hold); end
    checks++; if (bus.out_tx_start_reg !== 1'b1) begin errors++; $display("FAIL hs_done_low got start %b want 1", bus.out_tx_start_reg); end
    @(negedge clk);
    checks++; if (bus.out_tx_start_reg !== 1'b0) begin errors++; $display("FAIL hs_drop got start %b want 0", bus.out_tx_start_reg); end
    wait_idle(100, ok);
    checks++; if (!ok || log_id.size() != 1 || log_data[0] !== 8'hC3) begin errors++; $display("FAIL hs_xfer got %0d transfers want 1 of c3", log_id.size()); end
    stub_dly = 0;
  endtask

  task automatic test_reset_mid_wait();
    bit ok, found;
    stub_len = 20;
    log_id.delete(); log_data.delete();
    q[3].push_back({1'b1, 8'hE3});
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (busy && !bus.out_tx_start_reg && !bus.in_tx_done) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_reach_wait got busy %b start %b want WAIT", busy, bus.out_tx_start_reg); end
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    @(negedge clk);
    checks++;
    if (bus.out_req_ready_reg !== 4'b0000 || bus.out_tx_start_reg !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || bus.out_tx_data_reg !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid got ready %b start %b busy %b grant %0d data %h want all zero", bus.out_req_ready_reg, bus.out_tx_start_reg, busy, grant_id, bus.out_tx_data_reg);
    end
    rst_n    = 1'b1;
    stub_len = 4;
    log_id.delete(); log_data.delete();
    q[3].push_back({1'b1, 8'hF3});
    q[1].push_back({1'b1, 8'hF1});
    wait_idle(200, ok);
    checks++; if (!ok || log_id.size() != 2 || log_id[0] != 1 || log_id[1] != 3) begin errors++; $display("FAIL rst_rrptr got first id %0d count %0d want 1 then 3", (log_id.size() > 0) ? log_id[0] : -1, log_id.size()); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_byte();
    test_packet_lock();
    test_pkt_max();
    test_handshake();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
